// File: rtl/tick_sched_pkg.sv
// Shared constants and types for the tick_sched millisecond timer scheduler:
// register addresses, data_in field offsets, status bits and FSM states.
package tick_sched_pkg;

  localparam logic [1:0] ADDR_ARM  = 2'd0;
  localparam logic [1:0] ADDR_PEND = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_STAT = 2'd3;

  localparam int SLOT_IDX_LSB   = 16;
  localparam int SLOT_IDX_W     = 4;
  localparam int ONESHOT_BIT    = 24;
  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_OVR_BIT   = 1;
  localparam int STAT_NSLOT_LSB = 8;
  localparam int STAT_NSLOT_W   = 5;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/tick_sched.sv
// Millisecond software-timer scheduler: num_slots 16-bit countdown slots scanned once per ms_tick
// through one shared decrement/reload path. Optional oneshot support via TICK_SCHED_ONESHOT_EN.
module tick_sched
  import tick_sched_pkg::*;
#(
  parameter int num_slots = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ms_tick,
  input  logic        stb,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack,
  output logic        irq
);

  localparam logic [SLOT_IDX_W-1:0] LAST_IDX = SLOT_IDX_W'(num_slots - 1);

  state_e                state_q, state_d;
  logic [SLOT_IDX_W-1:0] idx_q, idx_d;
  logic                  tick_q, tick_d;
  logic                  overrun_q, overrun_d;
  logic [15:0]           period_q [num_slots];
  logic [15:0]           period_d [num_slots];
  logic [15:0]           cnt_q    [num_slots];
  logic [15:0]           cnt_d    [num_slots];
  logic [num_slots-1:0]  en_q, en_d;
  logic [num_slots-1:0]  pend_q, pend_d;
  logic [num_slots-1:0]  oneshot_mask;

  logic                  wr, arm_we, pend_we, mask_we, stat_we, busy;
  logic [SLOT_IDX_W-1:0] arm_idx;
  logic [15:0]           arm_period;
  logic [num_slots-1:0]  cpu_hit;
  logic                  unused_data;

`ifdef TICK_SCHED_ONESHOT_EN
  logic [num_slots-1:0]  oneshot_q, oneshot_d;
  assign oneshot_mask = oneshot_q;
  assign unused_data  = ^{data_in[31:25], data_in[23:20]};
`else
  assign oneshot_mask = '0;
  assign unused_data  = ^data_in[31:20];
`endif

  assign wr         = stb & we;
  assign arm_idx    = data_in[SLOT_IDX_LSB +: SLOT_IDX_W];
  assign arm_period = data_in[15:0];
  assign arm_we     = wr && (addr == ADDR_ARM) && (int'(arm_idx) < num_slots);
  assign pend_we    = wr && (addr == ADDR_PEND);
  assign mask_we    = wr && (addr == ADDR_MASK);
  assign stat_we    = wr && (addr == ADDR_STAT);
  assign busy       = (state_q == SCAN);
  assign ack        = stb;
  assign irq        = |pend_q;

  // A CPU arm/disable of a slot suppresses whatever the scan would do to it this cycle.
  always_comb begin
    for (int i = 0; i < num_slots; i++) begin
      cpu_hit[i] = (arm_we && (arm_idx == SLOT_IDX_W'(i))) || (mask_we && data_in[i]);
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tick_d    = tick_q;
    overrun_d = overrun_q;
    period_d  = period_q;
    cnt_d     = cnt_q;
    en_d      = en_q;
    pend_d    = pend_q;
`ifdef TICK_SCHED_ONESHOT_EN
    oneshot_d = oneshot_q;
`endif

    if (stat_we && data_in[STAT_OVR_BIT]) overrun_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (ms_tick || tick_q) begin
          state_d = SCAN;
          idx_d   = '0;
          tick_d  = 1'b0;
          if (ms_tick && tick_q) overrun_d = 1'b1;
        end
      end
      SCAN: begin
        if (ms_tick) begin
          if (tick_q) overrun_d = 1'b1;
          else        tick_d    = 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear goes first so a same-cycle expiry set wins.
    if (pend_we) pend_d = pend_q & ~data_in[num_slots-1:0];

    for (int i = 0; i < num_slots; i++) begin
      if (busy && (idx_q == SLOT_IDX_W'(i)) && en_q[i] && !cpu_hit[i]) begin
        if (cnt_q[i] == 16'd1) begin
          pend_d[i] = 1'b1;
          cnt_d[i]  = period_q[i];
          if (oneshot_mask[i]) en_d[i] = 1'b0;
        end else begin
          cnt_d[i] = cnt_q[i] - 16'd1;
        end
      end
      if (arm_we && (arm_idx == SLOT_IDX_W'(i))) begin
        period_d[i] = arm_period;
        cnt_d[i]    = arm_period;
        en_d[i]     = |arm_period;
`ifdef TICK_SCHED_ONESHOT_EN
        oneshot_d[i] = data_in[ONESHOT_BIT];
`endif
      end
      if (mask_we && data_in[i]) en_d[i] = 1'b0;
    end
  end

  always_comb begin
    data_out = '0;
    if (stb && !we) begin
      case (addr)
        ADDR_ARM:  data_out[num_slots-1:0] = en_q;
        ADDR_PEND: data_out[num_slots-1:0] = pend_q;
        ADDR_MASK: data_out[num_slots-1:0] = oneshot_mask;
        ADDR_STAT: begin
          data_out[STAT_BUSY_BIT]                     = busy;
          data_out[STAT_OVR_BIT]                      = overrun_q;
          data_out[STAT_NSLOT_LSB +: STAT_NSLOT_W]    = STAT_NSLOT_W'(num_slots);
        end
        default: data_out = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      tick_q    <= 1'b0;
      overrun_q <= 1'b0;
      en_q      <= '0;
      pend_q    <= '0;
`ifdef TICK_SCHED_ONESHOT_EN
      oneshot_q <= '0;
`endif
      for (int i = 0; i < num_slots; i++) begin
        period_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tick_q    <= tick_d;
      overrun_q <= overrun_d;
      en_q      <= en_d;
      pend_q    <= pend_d;
`ifdef TICK_SCHED_ONESHOT_EN
      oneshot_q <= oneshot_d;
`endif
      period_q  <= period_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule
